multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style FSM that sequences the multi-cycle MIPS datapath.
- Lets one ALU and one unified instruction/data memory be shared across the fetch, decode, execute, memory and writeback steps.
- Sits beside the datapath: it reads the opcode from the instruction register and drives every mux select, enable and ALU-op line.
- Memory accesses use a ready handshake, so the core tolerates multi-cycle memory.

Parameters:
STATE_W, 4, width of state encoding and of state_o.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
opcode_i  input  6  instr[31:26] from the datapath instruction register.
mem_ready_i  input  1  memory completes the current read/write this cycle.
pc_write_o  output  1  unconditional PC load.
branch_eq_o  output  1  PC load if ALU zero.
branch_ne_o  output  1  PC load if not zero.
i_or_d_o  output  1  memory address: 0=PC, 1=ALUOut.
mem_read_o  output  1  memory read request.
mem_write_o  output  1  memory write request.
ir_write_o  output  1  instruction register load.
reg_dst_o  output  2  write register: 00=rt, 01=rd, 10=$31.
mem_to_reg_o  output  2  write data: 00=ALUOut, 01=MDR, 10=PC.
reg_write_o  output  1  register file write enable.
alu_src_a_o  output  1  0=PC, 1=rs.
alu_src_b_o  output  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
alu_op_o  output  3  000=add, 001=sub, 100=addi, 101=ori, 110=lui, 111=R-type (funct decode).
pc_source_o  output  2  00=ALU result, 01=ALUOut, 10=jump target.
illegal_op_o  output  1  one-cycle pulse on an unsupported opcode.
state_o  output  STATE_W  current state, for debug.

Behaviour:
- Reset:
  - reset=0 forces state RESET_S immediately, regardless of clock.
  - In RESET_S all outputs are 0 and state_o=0.
  - The first rising clk with reset=1 enters FETCH.
  - Reset asserted mid-instruction aborts it; no further write enables are asserted.
- Supported opcodes: R=0x00, J=0x02, JAL=0x03, BEQ=0x04, BNE=0x05, ADDI=0x08, ORI=0x0D, LUI=0x0F, LW=0x23, SW=0x2B.
- Outputs not listed for a state are 0.
- States and transitions:
  - FETCH:
    - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
    - ir_write and pc_write assert only when mem_ready_i=1.
    - Stays in FETCH while mem_ready_i=0; goes to DECODE on ready.
  - DECODE:
    - Outputs: alu_src_a=0, alu_src_b=11, alu_op=000 (precompute branch target).
    - Samples opcode_i into an internal register; later states use only that register.
    - Next state: LW/SW->MEM_ADDR, R->R_EXEC, ADDI/ORI/LUI->I_EXEC, BEQ/BNE->BRANCH, J/JAL->JUMP.
    - Any other opcode: illegal_op_o=1 for this cycle, next state FETCH.
  - MEM_ADDR:
    - Outputs: alu_src_a=1, alu_src_b=10, alu_op=000.
    - Next state: MEM_RD for LW, MEM_WR for SW.
  - MEM_RD:
    - Outputs: mem_read=1, i_or_d=1.
    - Holds until mem_ready_i=1, then goes to MEM_WB.
  - MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; then FETCH.
  - MEM_WR:
    - Outputs: mem_write=1, i_or_d=1.
    - Holds until mem_ready_i=1, then goes to FETCH.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=111; then R_WB.
  - R_WB: reg_write=1, reg_dst=01, mem_to_reg=00; then FETCH.
  - I_EXEC:
    - Outputs: alu_src_a=1, alu_src_b=10.
    - alu_op: 100 for ADDI, 101 for ORI, 110 for LUI.
    - Next state I_WB.
  - I_WB: reg_write=1, reg_dst=00, mem_to_reg=00; then FETCH.
  - BRANCH:
    - Outputs: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01.
    - branch_eq=1 for BEQ, branch_ne=1 for BNE (never both).
    - Next state FETCH.
  - JUMP:
    - Outputs: pc_write=1, pc_source=10.
    - For JAL also reg_write=1, reg_dst=10, mem_to_reg=10.
    - Next state FETCH.
- Latency with mem_ready_i tied to 1: BEQ/BNE/J/JAL 3 cycles, R/I/SW 4 cycles, LW 5 cycles.
  - Each cycle of mem_ready_i=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Invariants:
  - mem_read and mem_write are never asserted together.
  - reg_write is asserted only in MEM_WB, R_WB, I_WB and JUMP (JAL).
  - opcode_i changing outside DECODE has no effect.
- Unreachable state encodings go to FETCH on the next clock.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state enumeration (RESET_S=0, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP);
  - the opcode localparams;
  - the alu_op, alu_src_b, pc_source, reg_dst and mem_to_reg encodings.
- One combinational sub-module, mc_output_decode, maps (state, latched opcode, mem_ready_i) to the output vector.
- The top holds the state and opcode registers and the next-state logic.

Test Plan:
- Reset then release, mem_ready_i=1, opcode 0x00 -> state sequence FETCH, DECODE, R_EXEC, R_WB, FETCH; reg_write=1 with reg_dst=01 only in R_WB; alu_op=111 in R_EXEC.
- LW (0x23) with mem_ready_i=0 for 2 cycles in MEM_RD -> MEM_RD held 3 cycles; MEM_WB asserts reg_write=1, mem_to_reg=01; total 7 cycles.
- SW (0x2B) -> mem_write=1, i_or_d=1 for exactly one cycle; reg_write stays 0 throughout.
- BNE (0x05) -> BRANCH asserts branch_ne=1, branch_eq=0, pc_source=01, alu_op=001; JAL (0x03) -> JUMP asserts pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10.
- Opcode 0x3F -> illegal_op_o pulses high for 1 cycle in DECODE, next state FETCH, no write enables asserted.
- reset driven low asynchronously mid-MEM_WR -> all outputs 0 within the same cycle, state_o=0; after release, next state is FETCH.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes,
// opcodes, datapath select encodings and the packed control vector.
package mips_ctrl_pkg;

  localparam int STATE_BITS = 4;
  typedef logic [STATE_BITS-1:0] state_t;

  localparam state_t RESET_S  = 4'd0;
  localparam state_t FETCH    = 4'd1;
  localparam state_t DECODE   = 4'd2;
  localparam state_t MEM_ADDR = 4'd3;
  localparam state_t MEM_RD   = 4'd4;
  localparam state_t MEM_WB   = 4'd5;
  localparam state_t MEM_WR   = 4'd6;
  localparam state_t R_EXEC   = 4'd7;
  localparam state_t R_WB     = 4'd8;
  localparam state_t I_EXEC   = 4'd9;
  localparam state_t I_WB     = 4'd10;
  localparam state_t BRANCH   = 4'd11;
  localparam state_t JUMP     = 4'd12;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_ORI   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle. The datapath is the master
// (supplies opcode and memory ready), the controller is the slave.
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode_i;
  logic               mem_ready_i;
  logic               pc_write_o;
  logic               branch_eq_o;
  logic               branch_ne_o;
  logic               i_or_d_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic               ir_write_o;
  logic [1:0]         reg_dst_o;
  logic [1:0]         mem_to_reg_o;
  logic               reg_write_o;
  logic               alu_src_a_o;
  logic [1:0]         alu_src_b_o;
  logic [2:0]         alu_op_o;
  logic [1:0]         pc_source_o;
  logic               illegal_op_o;
  logic [STATE_W-1:0] state_o;

  modport master (
    output opcode_i, mem_ready_i,
    input  pc_write_o, branch_eq_o, branch_ne_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o, illegal_op_o,
           state_o
  );

  modport slave (
    input  opcode_i, mem_ready_i,
    output pc_write_o, branch_eq_o, branch_ne_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o, illegal_op_o,
           state_o
  );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// Moore output decode: state plus instruction opcode to datapath controls.
// Only FETCH additionally looks at mem_ready to qualify its register loads.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
        case (opcode)
          OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE,
          OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: ctrl.illegal_op = 1'b0;
          default:                               ctrl.illegal_op = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = WB_MDR;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_RTYPE;
      end
      R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RD;
        ctrl.mem_to_reg = WB_ALUOUT;
      end
      I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        case (opcode)
          OP_ADDI: ctrl.alu_op = ALU_ADDI;
          OP_ORI:  ctrl.alu_op = ALU_ORI;
          default: ctrl.alu_op = ALU_LUI;
        endcase
      end
      I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = WB_ALUOUT;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.branch_eq = (opcode == OP_BEQ);
        ctrl.branch_ne = (opcode == OP_BNE);
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        if (opcode == OP_JAL) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REGDST_RA;
          ctrl.mem_to_reg = WB_PC;
        end
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: state and latched-opcode registers plus
// next-state logic; output decode lives in mc_output_decode.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input logic                clk,
  input logic                reset,
  multicycle_control_if.slave bus
);

  state_t     state_q;
  state_t     next_state;
  logic [5:0] op_q;
  logic [5:0] dec_op;
  ctrl_t      ctrl;

  // DECODE must act on the live opcode since op_q only loads at its end.
  assign dec_op = (state_q == DECODE) ? bus.opcode_i : op_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_S;
      op_q    <= '0;
    end else begin
      state_q <= next_state;
      if (state_q == DECODE) op_q <= bus.opcode_i;
    end
  end

  always_comb begin
    next_state = FETCH;
    case (state_q)
      RESET_S: next_state = FETCH;
      FETCH:   next_state = bus.mem_ready_i ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode_i)
          OP_LW, OP_SW:            next_state = MEM_ADDR;
          OP_R:                    next_state = R_EXEC;
          OP_ADDI, OP_ORI, OP_LUI: next_state = I_EXEC;
          OP_BEQ, OP_BNE:          next_state = BRANCH;
          OP_J, OP_JAL:            next_state = JUMP;
          default:                 next_state = FETCH;
        endcase
      end
      MEM_ADDR: next_state = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   next_state = bus.mem_ready_i ? MEM_WB : MEM_RD;
      MEM_WR:   next_state = bus.mem_ready_i ? FETCH : MEM_WR;
      R_EXEC:   next_state = R_WB;
      I_EXEC:   next_state = I_WB;
      default:  next_state = FETCH;
    endcase
  end

  mc_output_decode u_output_decode (
    .state     (state_q),
    .opcode    (dec_op),
    .mem_ready (bus.mem_ready_i),
    .ctrl      (ctrl)
  );

  assign bus.pc_write_o   = ctrl.pc_write;
  assign bus.branch_eq_o  = ctrl.branch_eq;
  assign bus.branch_ne_o  = ctrl.branch_ne;
  assign bus.i_or_d_o     = ctrl.i_or_d;
  assign bus.mem_read_o   = ctrl.mem_read;
  assign bus.mem_write_o  = ctrl.mem_write;
  assign bus.ir_write_o   = ctrl.ir_write;
  assign bus.reg_dst_o    = ctrl.reg_dst;
  assign bus.mem_to_reg_o = ctrl.mem_to_reg;
  assign bus.reg_write_o  = ctrl.reg_write;
  assign bus.alu_src_a_o  = ctrl.alu_src_a;
  assign bus.alu_src_b_o  = ctrl.alu_src_b;
  assign bus.alu_op_o     = ctrl.alu_op;
  assign bus.pc_source_o  = ctrl.pc_source;
  assign bus.illegal_op_o = ctrl.illegal_op;
  assign bus.state_o      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle plans built
// from the instruction-level step rules, driven with random stalls/opcodes.
module tb_multicycle_control;

  localparam int S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3,
                 S_MEM_RD = 4, S_MEM_WB = 5, S_MEM_WR = 6, S_R_EXEC = 7,
                 S_R_WB = 8, S_I_EXEC = 9, S_I_WB = 10, S_BRANCH = 11,
                 S_JUMP = 12;

  typedef struct {
    logic        ready;
    logic [5:0]  opc;
    int          st;
    logic [20:0] outs;
  } step_t;

  logic  clk = 1'b0;
  logic  reset;
  int    n_checks = 0;
  int    n_errors = 0;
  step_t plan[$];

  multicycle_control_if #(.STATE_W(4)) bus ();

  multicycle_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D,
                      6'h0F, 6'h23, 6'h2B};
  endfunction

  // Expected control outputs for one cycle, from the per-step table.
  function automatic logic [20:0] exp_out(input int st, input logic [5:0] op,
                                          input logic rdy);
    logic pcw, beq, bne, iord, mr, mw, irw, rw, asa, ill;
    logic [1:0] rd, m2r, asb, pcs;
    logic [2:0] aop;
    {pcw, beq, bne, iord, mr, mw, irw, rw, asa, ill} = '0;
    {rd, m2r, asb, pcs} = '0;
    aop = '0;
    case (st)
      S_FETCH:    begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE:   begin asb = 2'b11; ill = !is_legal(op); end
      S_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      S_MEM_RD:   begin mr = 1; iord = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 2'b01; end
      S_MEM_WR:   begin mw = 1; iord = 1; end
      S_R_EXEC:   begin asa = 1; aop = 3'b111; end
      S_R_WB:     begin rw = 1; rd = 2'b01; end
      S_I_EXEC: begin
        asa = 1; asb = 2'b10;
        aop = (op == 6'h08) ? 3'b100 : (op == 6'h0D) ? 3'b101 : 3'b110;
      end
      S_I_WB:     rw = 1;
      S_BRANCH: begin
        asa = 1; aop = 3'b001; pcs = 2'b01;
        beq = (op == 6'h04); bne = (op == 6'h05);
      end
      S_JUMP: begin
        pcw = 1; pcs = 2'b10;
        if (op == 6'h03) begin rw = 1; rd = 2'b10; m2r = 2'b10; end
      end
      default: ;
    endcase
    return {pcw, beq, bne, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, ill};
  endfunction

  function automatic logic [20:0] dut_outs();
    return {bus.pc_write_o, bus.branch_eq_o, bus.branch_ne_o, bus.i_or_d_o,
            bus.mem_read_o, bus.mem_write_o, bus.ir_write_o, bus.reg_dst_o,
            bus.mem_to_reg_o, bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o,
            bus.alu_op_o, bus.pc_source_o, bus.illegal_op_o};
  endfunction

  // Opcode on the bus is random garbage everywhere except the DECODE cycle.
  task automatic add(input int st, input logic rdy, input logic [5:0] op);
    step_t s;
    s.st    = st;
    s.ready = rdy;
    s.opc   = (st == S_DECODE) ? op : 6'($urandom);
    s.outs  = exp_out(st, op, rdy);
    plan.push_back(s);
  endtask

  task automatic build_plan(input logic [5:0] op, input int sf, input int sm);
    plan.delete();
    for (int i = 0; i < sf; i++) add(S_FETCH, 1'b0, op);
    add(S_FETCH, 1'b1, op);
    add(S_DECODE, 1'($urandom), op);
    case (op)
      6'h23: begin
        add(S_MEM_ADDR, 1'($urandom), op);
        for (int i = 0; i < sm; i++) add(S_MEM_RD, 1'b0, op);
        add(S_MEM_RD, 1'b1, op);
        add(S_MEM_WB, 1'($urandom), op);
      end
      6'h2B: begin
        add(S_MEM_ADDR, 1'($urandom), op);
        for (int i = 0; i < sm; i++) add(S_MEM_WR, 1'b0, op);
        add(S_MEM_WR, 1'b1, op);
      end
      6'h00: begin add(S_R_EXEC, 1'($urandom), op); add(S_R_WB, 1'($urandom), op); end
      6'h08, 6'h0D, 6'h0F: begin
        add(S_I_EXEC, 1'($urandom), op); add(S_I_WB, 1'($urandom), op);
      end
      6'h04, 6'h05: add(S_BRANCH, 1'($urandom), op);
      6'h02, 6'h03: add(S_JUMP, 1'($urandom), op);
      default: ;
    endcase
  endtask

  task automatic run_step(input step_t s);
    @(negedge clk);
    bus.opcode_i    = s.opc;
    bus.mem_ready_i = s.ready;
    #1;
    check_val("state", 32'(bus.state_o), 32'(s.st));
    check_val("outs", 32'(dut_outs()), 32'(s.outs));
  endtask

  task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
    build_plan(op, sf, sm);
    foreach (plan[i]) run_step(plan[i]);
  endtask

  logic [5:0] legal_ops[10] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                 6'h0D, 6'h0F, 6'h23, 6'h2B};

  initial begin
    reset           = 1'b0;
    bus.opcode_i    = '0;
    bus.mem_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_val("reset_state", 32'(bus.state_o), 32'd0);
    check_val("reset_outs", 32'(dut_outs()), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed sequences.
    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 0, 2);
    run_instr(6'h2B, 0, 0);
    run_instr(6'h05, 0, 0);
    run_instr(6'h03, 0, 0);
    run_instr(6'h3F, 0, 0);
    run_instr(6'h04, 2, 0);

    // Asynchronous reset in the middle of a stalled store.
    build_plan(6'h2B, 1, 3);
    foreach (plan[i]) begin
      run_step(plan[i]);
      if (plan[i].st == S_MEM_WR) break;
    end
    #1;
    reset = 1'b0;
    #1;
    check_val("async_rst_state", 32'(bus.state_o), 32'd0);
    check_val("async_rst_outs", 32'(dut_outs()), 32'd0);
    @(negedge clk);
    #1;
    check_val("rst_hold_state", 32'(bus.state_o), 32'd0);
    reset = 1'b1;
    run_instr(6'h0D, 0, 0);

    // Random instruction stream with random stalls and opcode noise.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 9)];
      else op = 6'($urandom);
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
